// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared FSM state type and result-mux selects for alu_divider
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [3:0] SEL_DIV_Q = 4'b1000;
  localparam logic [3:0] SEL_DIV_R = 4'b1001;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_step
  import alu_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0] shifted;

  // A set top bit already exceeds any N-bit divisor; the low N bits of the
  // modular difference are then exact because the true result is < divisor.
  assign shifted = {rem_in, bit_in};
  assign q_bit   = shifted[N] | (shifted[N-1:0] >= divisor);
  assign rem_out = q_bit ? (shifted[N-1:0] - divisor) : shifted[N-1:0];

endmodule

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative radix-2 restoring divider for the execute stage
// Optional zero-quotient early-out when ALU_DIV_EARLY_OUT_EN is defined.
module alu_divider
  import alu_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int CW = $clog2(N);

  div_state_t      state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    dvd;
  logic [N-1:0]    quo;
  logic [N-1:0]    rem;
  logic [N-1:0]    dvs;
  logic            neg_q;
  logic            neg_r;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;
  logic [N-1:0]    step_rem;
  logic            step_q;

  assign a_mag = (signed_op && a[N-1]) ? -a : a;
  assign b_mag = (signed_op && b[N-1]) ? -b : b;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  div_step #(.N(N)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[N-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        CALC: begin
          rem <= step_rem;
          dvd <= {dvd[N-2:0], 1'b0};
          quo <= {quo[N-2:0], step_q};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          quotient    <= neg_q ? -quo : quo;
          remainder   <= neg_r ? -rem : rem;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back issue.
          if (start) begin
            if (b == '0) begin
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
`ifdef ALU_DIV_EARLY_OUT_EN
            else if (a_mag < b_mag) begin
              quotient    <= '0;
              remainder   <= a;
              div_by_zero <= 1'b0;
              state       <= DONE;
            end
`endif
            else begin
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              quo   <= '0;
              cnt   <= CW'(N - 1);
              neg_q <= signed_op & (a[N-1] ^ b[N-1]);
              neg_r <= signed_op & a[N-1];
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// tb/tb_alu_divider.sv - scoreboard testbench for alu_divider (N=4)
module tb_alu_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic       signed_op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [3:0] quotient;
  logic [3:0] remainder;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t scb[$];
  int   tests = 0;
  int   fails = 0;

  alu_divider #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [3:0] av, input logic [3:0] bv);
    exp_t e;
    int   sa, sd, ma, mb;
    if (bv == 4'd0) begin
      e.q = 4'hF; e.r = av; e.dbz = 1'b1; e.lat = 1;
      return e;
    end
    if (s) begin
      sa = $signed(av);
      sd = $signed(bv);
    end else begin
      sa = int'(av);
      sd = int'(bv);
    end
    e.q   = 4'(sa / sd);
    e.r   = 4'(sa % sd);
    e.dbz = 1'b0;
    e.lat = 6;
    ma = (sa < 0) ? -sa : sa;
    mb = (sd < 0) ? -sd : sd;
`ifdef ALU_DIV_EARLY_OUT_EN
    if (ma < mb) e.lat = 1;
`else
    if (ma < 0 || mb < 0) e.lat = 0;
`endif
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [3:0] av, input logic [3:0] bv);
    signed_op = s;
    a         = av;
    b         = bv;
    start     = 1'b1;
    scb.push_back(model(s, av, bv));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output int busy_n);
    cyc    = c0;
    busy_n = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_n++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = 4'd0; b = 4'd0;
    #12;
    tests++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs got %b exp 0", {busy, done, div_by_zero, quotient, remainder});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned;
    exp_t e;
    int   cyc, bn;
    issue(1'b0, 4'd13, 4'd3);
    wait_done(1, cyc, bn);
    e = scb.pop_front();
    tests++; if (quotient !== e.q)     begin fails++; $display("FAIL unsigned_q got %h exp %h", quotient, e.q); end
    tests++; if (remainder !== e.r)    begin fails++; $display("FAIL unsigned_r got %h exp %h", remainder, e.r); end
    tests++; if (div_by_zero !== e.dbz) begin fails++; $display("FAIL unsigned_dbz got %b exp %b", div_by_zero, e.dbz); end
    tests++; if (cyc !== e.lat)        begin fails++; $display("FAIL unsigned_latency got %0d exp %0d", cyc, e.lat); end
    tests++; if (bn !== 5)             begin fails++; $display("FAIL unsigned_busy_cycles got %0d exp 5", bn); end
    tick();
    tests++; if (done !== 1'b0)        begin fails++; $display("FAIL done_pulse_width got %b exp 0", done); end
  endtask

  task automatic test_signed;
    logic [8:0] tbl [3];
    exp_t e;
    int   cyc, bn;
    tbl[0] = {1'b1, 4'b1001, 4'b0010};
    tbl[1] = {1'b1, 4'b1000, 4'b1111};
    tbl[2] = {1'b1, 4'b0111, 4'b1110};
    for (int i = 0; i < 3; i++) begin
      tick();
      issue(tbl[i][8], tbl[i][7:4], tbl[i][3:0]);
      wait_done(1, cyc, bn);
      e = scb.pop_front();
      tests++; if (quotient !== e.q)  begin fails++; $display("FAIL signed_q[%0d] got %h exp %h", i, quotient, e.q); end
      tests++; if (remainder !== e.r) begin fails++; $display("FAIL signed_r[%0d] got %h exp %h", i, remainder, e.r); end
      tests++; if (cyc !== e.lat)     begin fails++; $display("FAIL signed_latency[%0d] got %0d exp %0d", i, cyc, e.lat); end
    end
  endtask

  task automatic test_div_zero;
    logic [8:0] tbl [3];
    exp_t e;
    int   cyc, bn;
    tbl[0] = {1'b0, 4'b0110, 4'b0000};
    tbl[1] = {1'b1, 4'b1010, 4'b0000};
    tbl[2] = {1'b0, 4'b1001, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      tick();
      issue(tbl[i][8], tbl[i][7:4], tbl[i][3:0]);
      wait_done(1, cyc, bn);
      e = scb.pop_front();
      tests++; if (quotient !== e.q)      begin fails++; $display("FAIL dz_q[%0d] got %h exp %h", i, quotient, e.q); end
      tests++; if (remainder !== e.r)     begin fails++; $display("FAIL dz_r[%0d] got %h exp %h", i, remainder, e.r); end
      tests++; if (div_by_zero !== e.dbz) begin fails++; $display("FAIL dz_flag[%0d] got %b exp %b", i, div_by_zero, e.dbz); end
      tests++; if (cyc !== e.lat)         begin fails++; $display("FAIL dz_latency[%0d] got %0d exp %0d", i, cyc, e.lat); end
    end
  endtask

  task automatic test_start_while_busy;
    exp_t e;
    int   cyc, bn;
    tick();
    issue(1'b0, 4'd13, 4'd3);
    signed_op = 1'b1; a = 4'd9; b = 4'd2; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done(3, cyc, bn);
    e = scb.pop_front();
    tests++; if (quotient !== e.q)  begin fails++; $display("FAIL busy_start_q got %h exp %h", quotient, e.q); end
    tests++; if (remainder !== e.r) begin fails++; $display("FAIL busy_start_r got %h exp %h", remainder, e.r); end
    tests++; if (cyc !== e.lat)     begin fails++; $display("FAIL busy_start_latency got %0d exp %0d", cyc, e.lat); end
    tick();
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL busy_start_requeued got %b exp 00", {busy, done}); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   cyc, bn;
    tick();
    issue(1'b0, 4'd14, 4'd4);
    for (int i = 0; i < 2; i++) begin
      wait_done(1, cyc, bn);
      e = scb.pop_front();
      tests++; if (quotient !== e.q)  begin fails++; $display("FAIL b2b_q[%0d] got %h exp %h", i, quotient, e.q); end
      tests++; if (remainder !== e.r) begin fails++; $display("FAIL b2b_r[%0d] got %h exp %h", i, remainder, e.r); end
      tests++; if (cyc !== e.lat)     begin fails++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, cyc, e.lat); end
      if (i == 0) issue(1'b0, 4'd11, 4'd2);
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    int   cyc, bn;
    tick();
    issue(1'b0, 4'd15, 4'd2);
    tick();
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, quotient, remainder} !== 10'd0) begin
      fails++;
      $display("FAIL async_reset got %b exp 0", {busy, done, quotient, remainder});
    end
    scb.delete();
    tick();
    rst = 1'b0;
    tick();
    issue(1'b0, 4'd15, 4'd5);
    wait_done(1, cyc, bn);
    e = scb.pop_front();
    tests++; if (quotient !== e.q)  begin fails++; $display("FAIL post_reset_q got %h exp %h", quotient, e.q); end
    tests++; if (remainder !== e.r) begin fails++; $display("FAIL post_reset_r got %h exp %h", remainder, e.r); end
    tests++; if (cyc !== e.lat)     begin fails++; $display("FAIL post_reset_latency got %0d exp %0d", cyc, e.lat); end
  endtask

  task automatic test_early_out;
    exp_t e;
    int   cyc, bn;
    tick();
    issue(1'b0, 4'd2, 4'd9);
    wait_done(1, cyc, bn);
    e = scb.pop_front();
    tests++; if (quotient !== e.q)      begin fails++; $display("FAIL small_q got %h exp %h", quotient, e.q); end
    tests++; if (remainder !== e.r)     begin fails++; $display("FAIL small_r got %h exp %h", remainder, e.r); end
    tests++; if (div_by_zero !== e.dbz) begin fails++; $display("FAIL small_dbz got %b exp %b", div_by_zero, e.dbz); end
    tests++; if (cyc !== e.lat)         begin fails++; $display("FAIL small_latency got %0d exp %0d", cyc, e.lat); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    test_early_out();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Iterative radix-2 restoring divider for the CPU execute stage.
- Sits directly upstream of the ALU result mux. Quotient drives the mux input selected by 4'b1000; remainder drives the input selected by 4'b1001.
- Multi-cycle: it accepts operands on a start pulse, computes one bit per cycle, and signals completion with a one-cycle done pulse.
- Outputs stay stable until the next accepted start, so the mux can read them at any time.

Parameters:
- N, 4, operand/result width in bits (same N as the result mux); legal N >= 2.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only when not busy.
- signed_op  input  1  1 = two's-complement division, 0 = unsigned.
- a  input  N  dividend.
- b  input  N  divisor.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- div_by_zero  output  1  high with results when b was 0; held until next accepted start.
- quotient  output  N  result quotient to mux input 4'b1000.
- remainder  output  N  result remainder to mux input 4'b1001.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE.
  - busy, done, div_by_zero = 0; quotient, remainder = 0.
  - internal registers cleared. The operation in progress is discarded.
- FSM states:
  - IDLE: start=1 latches a, b and signed_op and moves to CALC. If b=0, it moves to DONE instead.
  - CALC: N cycles, counted by a log2-width counter that counts down from N-1. Each cycle does one restoring step on the magnitudes: shift the partial remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit if no borrow. After the count-0 step, go to FIX.
  - FIX: 1 cycle. Signed sign correction: quotient negated if sign(a) XOR sign(b); remainder takes the sign of a. Results are written to the output registers. Go to DONE.
  - DONE: 1 cycle. done=1. Go to IDLE, or straight to CALC/DONE if start=1 in this cycle (back-to-back accepted).
- busy is high in CALC and FIX, and low in IDLE and DONE.
- Latency: start sampled at edge k, done high during cycle k+N+2. Divide-by-zero: done during cycle k+1.
- Start while busy is ignored; it is neither queued nor an error. Operand changes while busy are ignored.
- Magnitudes for signed_op=1 are formed in an N-bit unsigned domain. The magnitude of the most-negative value is 2^(N-1), which is representable unsigned.
- Divide by zero: quotient = all ones, remainder = a (unmodified), div_by_zero = 1, no sign correction.
- Signed overflow (a = most negative, b = -1): quotient = most negative, remainder = 0. This falls out naturally; no special case.
- Result outputs and div_by_zero change only in FIX, or on the DONE entry for divide-by-zero. They are otherwise held.

Optional Feature:
- Macro: ALU_DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if b≠0 and |a| < |b| (unsigned compare of magnitudes), skip CALC/FIX and go to DONE.
  - Results: quotient = 0, remainder = a, div_by_zero = 0. Latency 1, done during cycle k+1.
- Undefined: every nonzero-divisor operation takes exactly N+2 cycles. This fixed latency is the default build.

Decomposition:
- Package alu_div_pkg:
  - state enum div_state_t {IDLE, CALC, FIX, DONE}.
  - constants SEL_DIV_Q = 4'b1000 and SEL_DIV_R = 4'b1001 for the decoder and mux.
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, incoming dividend bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Parameterised by N.

Test Plan:
- N=4, unsigned, a=13, b=3, start one cycle → done exactly 6 cycles after the start edge; quotient=4, remainder=1, div_by_zero=0, busy high for 5 cycles.
- N=4, signed, a=-7 (4'b1001), b=2 → quotient=-3 (4'b1101), remainder=-1 (4'b1111). Overflow case a=-8, b=-1 → quotient=4'b1000, remainder=0.
- N=4, b=0, a=4'b0110 → done 1 cycle after start; quotient=4'b1111, remainder=4'b0110, div_by_zero=1. A following valid division clears div_by_zero.
- Start pulsed again at cycle 2 of CALC with different operands → ignored; the original result is delivered. Start in the DONE cycle → second division accepted back-to-back, done 6 cycles later.
- rst asserted asynchronously mid-CALC → busy, done, quotient and remainder go to 0 immediately, not at the next edge. A new start after release completes correctly (e.g. 15/5 → 3, 0).
- With ALU_DIV_EARLY_OUT_EN, unsigned a=2, b=9 → done 1 cycle after start, quotient=0, remainder=2. Without the macro, the same stimulus gives done after 6 cycles with identical results.
